controle_pc: RTL and testbench
==============================

# controle_pc

Multi-cycle sequencer for the 8-bit program counter and instruction fetch of the nRISC core. It runs a fetch/execute/update loop. It owns the `halt`, `EscPC` and `overridePC` inputs of the PC register and the request/acknowledge handshake to instruction memory. It latches each fetched instruction into an instruction register and hands it to the datapath. The PC advances in exactly one cycle per instruction, either incrementing or loading a branch target.

## Interface
- `TIMEOUT`, default 15: maximum number of FETCH cycles allowed without `imem_ack` before a fault is raised. Legal range 1..255.

- `c`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  level; leaves IDLE when high.
- `imem_ack`  in  1  instruction memory acknowledge; `imem_data` is valid in the same cycle.
- `imem_data`  in  8  instruction word.
- `exec_done`  in  1  datapath finished the current instruction.
- `branch_en`  in  1  the current instruction redirects the PC; sampled with `exec_done`.
- `branch_target`  in  8  redirect address; sampled with `exec_done`.
- `halt_req`  in  1  the current instruction is a halt; sampled with `exec_done`.
- `resume`  in  1  leaves HALTED when high.
- `imem_req`  out  1  fetch request.
- `IR`  out  8  instruction register.
- `exec_start`  out  1  one-cycle pulse at the start of execution.
- `halt`  out  1  freezes the PC register when high.
- `EscPC`  out  1  selects loading `overridePC` into the PC instead of incrementing.
- `overridePC`  out  8  PC load value.
- `state`  out  3  current state encoding.
- `fault`  out  1  fetch timeout occurred; sticky.

## Operation
- State encoding: IDLE=0, FETCH=1, EXEC=2, UPDATE=3, HALTED=4, FAULT=5. Codes 6 and 7 are unreachable; if ever entered, the block goes to IDLE on the next edge.
- All outputs are registered or decoded purely from registered state. No input-to-output combinational path exists.
- `halt` = 0 only in UPDATE; it is 1 in every other state. The PC register has no reset of its own; holding `halt` high keeps it at its load value.
- IDLE: `start`=1 moves to FETCH.
- FETCH:
  - `imem_req` = 1 for the whole state.
  - Wait counter `cnt` (8 bits) is cleared on entry and increments on each FETCH cycle without an ack.
  - `imem_ack`=1: `IR <= imem_data`, go to EXEC.
  - Otherwise, if `cnt == TIMEOUT-1`: go to FAULT and set `fault`.
  - An ack in the same cycle as the timeout wins.
- EXEC:
  - `exec_start` = 1 in the first EXEC cycle only.
  - On `exec_done`=1, latch `br_q <= branch_en`, `tgt_q <= branch_target`, `hlt_q <= halt_req`.
  - Then go to HALTED if `halt_req`=1, otherwise to UPDATE.
  - `halt_req` has priority over `branch_en`; a branch on a halt instruction is discarded.
  - `exec_done` may arrive in the first EXEC cycle.
- UPDATE: lasts exactly one cycle.
  - `halt`=0, `EscPC`=`br_q`, `overridePC`=`tgt_q`.
  - The PC register takes the increment or the load on the closing edge.
  - Then go to FETCH.
- HALTED: `resume`=1 clears `br_q` and goes to UPDATE, so the PC increments past the halt instruction.
- FAULT: absorbing. All inputs are ignored; only `rst_n` exits.
- `EscPC` and `overridePC` are 0 outside UPDATE.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - state=IDLE, `IR`=0, `halt`=1, `EscPC`=0, `overridePC`=0.
  - `imem_req`=0, `exec_start`=0, `fault`=0.
  - `cnt`, `br_q`, `tgt_q`, `hlt_q` all 0.
- Minimum instruction period is 3 cycles: FETCH with ack in its first cycle, EXEC with `exec_done` in its first cycle, then UPDATE.
- `imem_req` rises in the cycle after the IDLE→FETCH or UPDATE→FETCH edge.
- `IR` changes only on the FETCH→EXEC edge and is stable through EXEC and UPDATE.
- With no ack, FAULT is entered on the edge ending FETCH cycle number `TIMEOUT`. `fault` is visible in the next cycle.
- One PC change per instruction, at the edge closing UPDATE. The PC does not change while in HALTED, IDLE or FAULT.

## Test plan
- Reset, then `start`=1; ack in 3rd FETCH cycle with `imem_data`=0x3A; `exec_done` 1 cycle after `exec_start` with `branch_en`=0 -> `IR`=0x3A, exactly one UPDATE cycle with `halt`=0 and `EscPC`=0, external PC goes 200→201.
- `exec_done` with `branch_en`=1 and `branch_target`=0x10 -> UPDATE shows `EscPC`=1 and `overridePC`=0x10; the next FETCH is at PC 0x10; `EscPC`=0 again in FETCH.
- `exec_done` with `halt_req`=1, `branch_en`=1, target 0x55 -> state=4 and `halt`=1 for 10 cycles with the PC unchanged; then `resume` -> UPDATE with `EscPC`=0 and the PC increments.
- `TIMEOUT`=15, no ack -> FAULT entered after exactly 15 FETCH cycles and `fault`=1; a later `start`, `imem_ack` or `resume` leaves state=5; `rst_n` low -> all outputs return to their reset values.
- Ack arriving exactly in FETCH cycle 15 with `TIMEOUT`=15 -> accepted, state=2, `fault`=0.
- `rst_n` asserted mid-EXEC, between clock edges -> state=0, `exec_start`=0 and `halt`=1 immediately, without waiting for a clock edge; no UPDATE occurs.

Source files
------------

// File: rtl/controle_pc.sv
// Fetch/execute/update sequencer for the nRISC 8-bit PC register and instruction fetch.
// All outputs come from registers or from a decode of the registered state.
module controle_pc #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       c,
  input  logic       rst_n,
  input  logic       start,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  input  logic       exec_done,
  input  logic       branch_en,
  input  logic [7:0] branch_target,
  input  logic       halt_req,
  input  logic       resume,
  output logic       imem_req,
  output logic [7:0] IR,
  output logic       exec_start,
  output logic       halt,
  output logic       EscPC,
  output logic [7:0] overridePC,
  output logic [2:0] state,
  output logic       fault
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    UPDATE = 3'd3,
    HALTED = 3'd4,
    FAULT  = 3'd5
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] ir_q, ir_d;
  logic       br_q, br_d;
  logic [7:0] tgt_q, tgt_d;
  logic       hlt_q, hlt_d;
  logic       fault_q, fault_d;
  logic       exec_start_q, exec_start_d;

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ir_q         <= '0;
      br_q         <= 1'b0;
      tgt_q        <= '0;
      hlt_q        <= 1'b0;
      fault_q      <= 1'b0;
      exec_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ir_q         <= ir_d;
      br_q         <= br_d;
      tgt_q        <= tgt_d;
      hlt_q        <= hlt_d;
      fault_q      <= fault_d;
      exec_start_q <= exec_start_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ir_d         = ir_q;
    br_d         = br_q;
    tgt_d        = tgt_q;
    hlt_d        = hlt_q;
    fault_d      = fault_q;
    exec_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          cnt_d   = '0;
        end
      end
      FETCH: begin
        // An ack on the timeout cycle still wins over the fault.
        if (imem_ack) begin
          ir_d         = imem_data;
          state_d      = EXEC;
          exec_start_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      EXEC: begin
        if (exec_done) begin
          br_d    = branch_en;
          tgt_d   = branch_target;
          hlt_d   = halt_req;
          state_d = halt_req ? HALTED : UPDATE;
        end
      end
      UPDATE: begin
        state_d = FETCH;
        cnt_d   = '0;
      end
      HALTED: begin
        // Dropping the branch makes the PC step past the halt instruction.
        if (resume) begin
          br_d    = 1'b0;
          hlt_d   = 1'b0;
          state_d = UPDATE;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem_req   = (state_q == FETCH);
  assign IR         = ir_q;
  assign exec_start = exec_start_q;
  assign halt       = (state_q != UPDATE) | hlt_q;
  assign EscPC      = (state_q == UPDATE) & br_q;
  assign overridePC = (state_q == UPDATE) ? tgt_q : '0;
  assign state      = state_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_controle_pc.sv
// Bench for controle_pc: external PC register, phase/counter reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_controle_pc;
  localparam int unsigned TO = 15;

  logic       c = 1'b0, rst_n = 1'b1;
  logic       start = 1'b0, imem_ack = 1'b0, exec_done = 1'b0;
  logic       branch_en = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic [7:0] imem_data = '0, branch_target = '0;
  logic       imem_req, exec_start, halt, EscPC, fault;
  logic [7:0] IR, overridePC;
  logic [2:0] state;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  controle_pc #(.TIMEOUT(TO)) dut (
    .c(c), .rst_n(rst_n), .start(start), .imem_ack(imem_ack), .imem_data(imem_data),
    .exec_done(exec_done), .branch_en(branch_en), .branch_target(branch_target),
    .halt_req(halt_req), .resume(resume), .imem_req(imem_req), .IR(IR),
    .exec_start(exec_start), .halt(halt), .EscPC(EscPC), .overridePC(overridePC),
    .state(state), .fault(fault)
  );

  always #5 c = ~c;

  // External PC register: no reset, frozen while halt is high.
  logic [7:0] pc = 8'd200;
  always @(posedge c) if (!halt) pc <= EscPC ? overridePC : pc + 8'd1;

  // Reference model: which phase we are in and how long we have been there.
  typedef enum int {P_IDLE = 0, P_FETCH = 1, P_EXEC = 2, P_UPD = 3, P_HALT = 4, P_FAULT = 5} phase_t;
  phase_t      ph = P_IDLE;
  int unsigned fetch_n = 0, exec_n = 0;
  logic [7:0]  m_ir = '0, m_tgt = '0, m_pc = 8'd200;
  logic        m_br = 1'b0;

  always @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      ph <= P_IDLE; fetch_n <= 0; exec_n <= 0; m_ir <= '0; m_tgt <= '0; m_br <= 1'b0;
    end else begin
      case (ph)
        P_IDLE:  if (start) begin ph <= P_FETCH; fetch_n <= 1; end
        P_FETCH: begin
          if (imem_ack) begin m_ir <= imem_data; ph <= P_EXEC; exec_n <= 1; end
          else if (fetch_n == TO) ph <= P_FAULT;
          else fetch_n <= fetch_n + 1;
        end
        P_EXEC: begin
          exec_n <= exec_n + 1;
          if (exec_done) begin
            m_tgt <= branch_target;
            m_br  <= branch_en && !halt_req;
            ph    <= halt_req ? P_HALT : P_UPD;
          end
        end
        P_UPD: begin
          m_pc <= m_br ? m_tgt : m_pc + 8'd1;
          ph <= P_FETCH; fetch_n <= 1;
        end
        P_HALT:  if (resume) begin m_br <= 1'b0; ph <= P_UPD; end
        default: ;
      endcase
    end
  end

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge c) begin
    check("state",      8'(state),      8'(ph));
    check("imem_req",   8'(imem_req),   8'(ph == P_FETCH));
    check("IR",         IR,             m_ir);
    check("exec_start", 8'(exec_start), 8'(ph == P_EXEC && exec_n == 1));
    check("halt",       8'(halt),       8'(ph != P_UPD));
    check("EscPC",      8'(EscPC),      8'(ph == P_UPD && m_br));
    check("overridePC", overridePC,     (ph == P_UPD) ? m_tgt : 8'h00);
    check("fault",      8'(fault),      8'(ph == P_FAULT));
    check("pc",         pc,             m_pc);
  end

  task automatic step();
    @(negedge c);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; imem_ack = 0; exec_done = 0; branch_en = 0; halt_req = 0; resume = 0;
  endtask

  logic [7:0] pc_before;
  int unsigned ack_div;

  initial begin
    #1 rst_n = 1'b0;
    step(); step();
    check("rst_state", 8'(state), 8'd0);
    check("rst_halt", 8'(halt), 8'd1);
    rst_n = 1'b1;
    // Plain increment with ack in the third FETCH cycle.
    start = 1; step(); start = 0;
    step(); step();
    check("fetch3_state", 8'(state), 8'd1);
    imem_ack = 1; imem_data = 8'h3A; step(); imem_ack = 0;
    check("ir_3a", IR, 8'h3A);
    check("exec_start_1st", 8'(exec_start), 8'd1);
    step();
    check("exec_start_2nd", 8'(exec_start), 8'd0);
    exec_done = 1; step(); exec_done = 0;
    check("upd_state", 8'(state), 8'd3);
    check("upd_halt", 8'(halt), 8'd0);
    check("upd_pc", pc, 8'd200);
    step();
    check("pc_201", pc, 8'd201);
    check("model_pc_201", m_pc, 8'd201);
    // Branch.
    imem_ack = 1; imem_data = 8'h77; step(); imem_ack = 0;
    exec_done = 1; branch_en = 1; branch_target = 8'h10; step(); clear_inputs();
    check("br_escpc", 8'(EscPC), 8'd1);
    check("br_ovr", overridePC, 8'h10);
    step();
    check("br_pc", pc, 8'h10);
    check("br_escpc_fetch", 8'(EscPC), 8'd0);
    check("model_pc_10", m_pc, 8'h10);
    // Halt with a discarded branch.
    imem_ack = 1; imem_data = 8'hF0; step(); imem_ack = 0;
    exec_done = 1; halt_req = 1; branch_en = 1; branch_target = 8'h55; step(); clear_inputs();
    for (int i = 0; i < 10; i++) begin
      check("halted_state", 8'(state), 8'd4);
      check("halted_pc", pc, 8'h10);
      step();
    end
    resume = 1; step(); resume = 0;
    check("resume_state", 8'(state), 8'd3);
    check("resume_escpc", 8'(EscPC), 8'd0);
    step();
    check("resume_pc", pc, 8'h11);
    check("model_pc_11", m_pc, 8'h11);
    // Timeout with no ack.
    repeat (TO - 1) step();
    check("fetch15_state", 8'(state), 8'd1);
    step();
    check("fault_state", 8'(state), 8'd5);
    check("fault_flag", 8'(fault), 8'd1);
    start = 1; imem_ack = 1; resume = 1; repeat (4) step(); clear_inputs();
    check("fault_absorb", 8'(state), 8'd5);
    #2 rst_n = 1'b0; #1;
    check("async_rst_state", 8'(state), 8'd0);
    check("async_rst_fault", 8'(fault), 8'd0);
    check("async_rst_req", 8'(imem_req), 8'd0);
    check("async_rst_ir", IR, 8'd0);
    step(); rst_n = 1'b1;
    // Ack in the last allowed FETCH cycle.
    start = 1; step(); start = 0;
    repeat (TO - 1) step();
    imem_ack = 1; imem_data = 8'hC3; step(); imem_ack = 0;
    check("late_ack_state", 8'(state), 8'd2);
    check("late_ack_fault", 8'(fault), 8'd0);
    check("late_ack_ir", IR, 8'hC3);
    // Reset mid-EXEC, between edges.
    pc_before = pc;
    #2 rst_n = 1'b0; #1;
    check("midexec_state", 8'(state), 8'd0);
    check("midexec_es", 8'(exec_start), 8'd0);
    check("midexec_halt", 8'(halt), 8'd1);
    repeat (3) step();
    check("midexec_pc", pc, pc_before);
    rst_n = 1'b1;
    // Randomized traffic in epochs with varying ack rates; each epoch begins with a reset.
    for (int e = 0; e < 24; e++) begin
      ack_div = (e % 3 == 0) ? 2 : ((e % 3 == 1) ? 6 : 20);
      #2 rst_n = 1'b0; step(); rst_n = 1'b1;
      for (int k = 0; k < 150; k++) begin
        start         = ($urandom_range(3) == 0);
        imem_ack      = ($urandom_range(ack_div - 1) == 0);
        imem_data     = 8'($urandom);
        exec_done     = ($urandom_range(2) == 0);
        branch_en     = ($urandom_range(1) == 0);
        branch_target = 8'($urandom);
        halt_req      = ($urandom_range(5) == 0);
        resume        = ($urandom_range(3) == 0);
        if ($urandom_range(119) == 0) begin
          #2 rst_n = 1'b0; step(); rst_n = 1'b1;
        end else begin
          step();
        end
      end
    end
    clear_inputs();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
